axil_wr_resp_slave: RTL and testbench
=====================================

// Module: axil_wr_resp_slave
// PURPOSE
// AXI-Lite write-path slave: accepts AW and W beats independently, commits the write into a
// local register file with byte strobes, then issues the B response (BRESP/BVALID) and holds it
// until BREADY. It is the producer stage feeding the write-response protocol checker and must
// satisfy every B-channel rule that checker enforces.
// PARAMETERS
// C_AXI_DATA_WIDTH  32  data width; register width; WSTRB width = C_AXI_DATA_WIDTH/8
// C_AXI_ADDR_WIDTH  8   byte address width
// NUM_REGS          16  register count; word index = AWADDR[C_AXI_ADDR_WIDTH-1:2]
// PORTS
// AXI_ACLK     in   1                      clock; all flops on rising edge
// AXI_ARESETN  in   1                      asynchronous active-low reset
// AXI_AWADDR   in   C_AXI_ADDR_WIDTH       write address
// AXI_AWVALID  in   1                      address valid
// AXI_AWREADY  out  1                      address ready
// AXI_WDATA    in   C_AXI_DATA_WIDTH       write data
// AXI_WSTRB    in   C_AXI_DATA_WIDTH/8     byte strobes
// AXI_WVALID   in   1                      data valid
// AXI_WREADY   out  1                      data ready
// AXI_BRESP    out  2                      2'b00 OKAY, 2'b10 SLVERR
// AXI_BVALID   out  1                      response valid
// AXI_BREADY   in   1                      response ready
// REG_FILE     out  NUM_REGS*C_AXI_DATA_WIDTH  flattened registers; reg i at [i*DW +: DW]
// SLVERR_CNT   out  8                      saturating count of SLVERR responses
// BEHAVIOUR
// - Reset (async assert, sync release): AWREADY=0, WREADY=0, BVALID=0, BRESP=2'b00,
//   all REG_FILE=0, SLVERR_CNT=0, aw_full=0, w_full=0, state=IDLE.
// - AWREADY, WREADY are registered. AWREADY=1 iff state==IDLE and !aw_full; WREADY likewise
//   with w_full. Both are low in the first cycle after reset release.
// - AW handshake (AWVALID&AWREADY) latches the address and sets aw_full. The W handshake
//   latches data and strobes and sets w_full. AW and W are accepted in either order or in the
//   same cycle. A second beat on a channel is not accepted while that channel is full.
// - State machine:
//   IDLE  -> WRITE  when aw_full & w_full, including when both are set on the same edge.
//   WRITE -> RESP   after one cycle. In WRITE, the commit occurs: if index < NUM_REGS, update
//         bytes with WSTRB[b]=1 and leave the others unchanged (WSTRB=0 still writes nothing and
//         returns OKAY); else no register changes, BRESP=SLVERR, and SLVERR_CNT increments,
//         saturating at 255. Clear aw_full and w_full. Set BVALID=1.
//   RESP  -> IDLE   on the edge with BVALID&BREADY. BVALID drops to 0 on that edge.
// - Latency: the last of AW/W is accepted at edge E. REG_FILE is updated and BVALID rises at
//   edge E+2. With BREADY held at 1, the next AWREADY/WREADY is high from edge E+3.
// - While BVALID=1 and BREADY=0: BVALID and BRESP are held stable every cycle, with no timeout.
// - AWREADY=WREADY=0 in WRITE and RESP, so there are no new acceptances during a response.
// - Address bits [1:0] are ignored. Index bits above log2(NUM_REGS) must be 0 for OKAY.
// - Reset mid-operation: the in-flight write is discarded with no partial commit. BVALID is 0
//   on the first cycle after release.
// - No X on BVALID, AWREADY, or WREADY at any time out of reset. BRESP is never X while
//   BVALID=1.
// TESTING
// 1. Same-cycle AW=0x08, W=0xDEADBEEF, WSTRB=0xF; BREADY=1 -> reg2=0xDEADBEEF;
//    BVALID 1 cycle with BRESP=00 two edges after acceptance.
// 2. W first (0x000000AA, WSTRB=0x1), AW=0x04 three cycles later -> reg1[7:0]=0xAA,
//    other bytes keep their prior value, BRESP=00.
// 3. AW=0x40 (index 16), NUM_REGS=16 -> no register changes, BRESP=10, SLVERR_CNT 0->1.
// 4. BREADY held 0 for 7 cycles after BVALID -> BVALID=1 and BRESP stable for all 7 cycles;
//    AWREADY=WREADY=0 throughout; IDLE follows the handshake.
// 5. ARESETN pulsed low while in RESP -> BVALID=0 immediately and on the first cycle after
//    release; the next write completes normally.
// 6. 300 back-to-back out-of-range writes -> SLVERR_CNT saturates at 255 with no wrap.

Source files
------------

// File: rtl/axil_wr_resp_slave.sv
// AXI-Lite write slave: independent AW/W acceptance, byte-strobed commit into a local
// register file, then a B response held until the master takes it.
module axil_wr_resp_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS         = 16
) (
    input  logic                                 AXI_ACLK,
    input  logic                                 AXI_ARESETN,
    input  logic [C_AXI_ADDR_WIDTH-1:0]          AXI_AWADDR,
    input  logic                                 AXI_AWVALID,
    output logic                                 AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]          AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]        AXI_WSTRB,
    input  logic                                 AXI_WVALID,
    output logic                                 AXI_WREADY,
    output logic [1:0]                           AXI_BRESP,
    output logic                                 AXI_BVALID,
    input  logic                                 AXI_BREADY,
    output logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] REG_FILE,
    output logic [7:0]                           SLVERR_CNT
);

    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = C_AXI_ADDR_WIDTH - 2;
    localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_RESP
    } state_e;

    state_e                                   state_q, state_d;
    logic                                     awready_q, awready_d;
    logic                                     wready_q, wready_d;
    logic                                     bvalid_q, bvalid_d;
    logic [1:0]                               bresp_q, bresp_d;
    logic                                     aw_full_q, aw_full_d;
    logic                                     w_full_q, w_full_d;
    logic [IDX_W-1:0]                         idx_q, idx_d;
    logic [C_AXI_DATA_WIDTH-1:0]              wdata_q, wdata_d;
    logic [STRB_W-1:0]                        wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0][C_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
    logic [7:0]                               slverr_cnt_q, slverr_cnt_d;

    logic             aw_hs;
    logic             w_hs;
    logic             idx_ok;
    logic [SEL_W-1:0] sel;

    // Byte-offset bits never select anything; word-aligned access only.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^AXI_AWADDR[1:0];

    assign aw_hs  = AXI_AWVALID & awready_q;
    assign w_hs   = AXI_WVALID & wready_q;
    assign idx_ok = (32'(idx_q) < NUM_REGS);
    assign sel    = idx_q[SEL_W-1:0];

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        aw_full_d    = aw_full_q;
        w_full_d     = w_full_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        regs_d       = regs_q;
        slverr_cnt_d = slverr_cnt_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            idx_d     = AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = AXI_WDATA;
            wstrb_d  = AXI_WSTRB;
        end

        case (state_q)
            S_IDLE: begin
                if (aw_full_q && w_full_q) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_ok) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) regs_d[sel][b*8 +: 8] = wdata_q[b*8 +: 8];
                    end
                    bresp_d = RESP_OKAY;
                end else begin
                    bresp_d = RESP_SLVERR;
                    if (slverr_cnt_q != 8'hFF) slverr_cnt_d = slverr_cnt_q + 8'd1;
                end
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                bvalid_d  = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (bvalid_q && AXI_BREADY) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready reflects the state being entered so a full channel stalls on the very next cycle.
        awready_d = (state_d == S_IDLE) && !aw_full_d;
        wready_d  = (state_d == S_IDLE) && !w_full_d;
    end

    // NOTE: the register file is reset along with the control flops because its reset value is visible on REG_FILE.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state_q      <= S_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            aw_full_q    <= 1'b0;
            w_full_q     <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            regs_q       <= '0;
            slverr_cnt_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            aw_full_q    <= aw_full_d;
            w_full_q     <= w_full_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            regs_q       <= regs_d;
            slverr_cnt_q <= slverr_cnt_d;
        end
    end

    assign AXI_AWREADY = awready_q;
    assign AXI_WREADY  = wready_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BRESP   = bresp_q;
    assign REG_FILE    = regs_q;
    assign SLVERR_CNT  = slverr_cnt_q;

endmodule

// File: tb/tb_axil_wr_resp_slave.sv
// Directed bench for axil_wr_resp_slave: latency, strobes, SLVERR, back-pressure,
// mid-response reset and counter saturation, against a small register-file model.
module tb_axil_wr_resp_slave;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     awaddr;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [NR*DW-1:0]  reg_file;
    logic [7:0]        slverr_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_regs [NR];
    logic [7:0]  exp_cnt;

    always #5 clk = ~clk;

    axil_wr_resp_slave #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(AW),
        .NUM_REGS        (NR)
    ) dut (
        .AXI_ACLK   (clk),
        .AXI_ARESETN(rst_n),
        .AXI_AWADDR (awaddr),
        .AXI_AWVALID(awvalid),
        .AXI_AWREADY(awready),
        .AXI_WDATA  (wdata),
        .AXI_WSTRB  (wstrb),
        .AXI_WVALID (wvalid),
        .AXI_WREADY (wready),
        .AXI_BRESP  (bresp),
        .AXI_BVALID (bvalid),
        .AXI_BREADY (bready),
        .REG_FILE   (reg_file),
        .SLVERR_CNT (slverr_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] dut_reg(input int i);
        return reg_file[i*DW +: DW];
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) check($sformatf("%s_reg%0d", tag, i), dut_reg(i), exp_regs[i]);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        exp_cnt = 8'd0;
    endtask

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        int idx;
        idx = int'(addr[7:2]);
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) if (strb[b]) exp_regs[idx][b*8 +: 8] = data[b*8 +: 8];
            resp = 2'b00;
        end else begin
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            resp = 2'b10;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge on which the later of AW/W was accepted.
    task automatic send(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int aw_dly, input int w_dly);
        int   cyc;
        logic aw_done, w_done, aw_hs, w_hs;
        cyc = 0; aw_done = 1'b0; w_done = 1'b0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            tick();
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) begin
                w_done = 1'b1;
                if (!aw_done) begin
                    check("wready_drops_when_w_full", wready, 1'b0);
                    check("awready_stays_while_aw_empty", awready, 1'b1);
                end
            end
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("send_accept_timeout", {aw_done, w_done}, 2'b11);
    endtask

    task automatic wait_bvalid();
        int n;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        check("bvalid_timeout", bvalid, 1'b1);
        check("b_latency", n, 2);
    endtask

    task automatic finish_resp(input string tag, input logic [1:0] exp_resp);
        wait_bvalid();
        check({tag, "_bresp"}, bresp, exp_resp);
        tick();
        check({tag, "_bvalid_drop"}, bvalid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] old;

        rst_n = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b1;
        model_clear();

        // Reset state and ready timing around release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_cnt", slverr_cnt, 8'd0);
        check_regs("rst");
        #2 rst_n = 1'b1;
        #1 check("release_awready_low", awready, 1'b0);
        check("release_wready_low", wready, 1'b0);
        tick();
        check("idle_awready", awready, 1'b1);
        check("idle_wready", wready, 1'b1);

        // 1: same-cycle AW/W, cycle-exact latency.
        old = exp_regs[2];
        model_write(8'h08, 32'hDEADBEEF, 4'hF, resp);
        send(8'h08, 32'hDEADBEEF, 4'hF, 0, 0);
        check("t1_e0_bvalid", bvalid, 1'b0);
        check("t1_e0_awready", awready, 1'b0);
        tick();
        check("t1_e1_bvalid", bvalid, 1'b0);
        check("t1_e1_reg2_old", dut_reg(2), old);
        tick();
        check("t1_e2_bvalid", bvalid, 1'b1);
        check("t1_e2_bresp", bresp, resp);
        check("t1_e2_reg2", dut_reg(2), 32'hDEADBEEF);
        tick();
        check("t1_e3_bvalid", bvalid, 1'b0);
        check("t1_e3_awready", awready, 1'b1);
        check("t1_e3_wready", wready, 1'b1);
        check_regs("t1");

        // 2: W first with one strobe, AW three cycles later.
        model_write(8'h04, 32'h11223344, 4'hF, resp);
        send(8'h04, 32'h11223344, 4'hF, 0, 0);
        finish_resp("t2_pre", resp);
        model_write(8'h04, 32'h000000AA, 4'h1, resp);
        send(8'h04, 32'h000000AA, 4'h1, 3, 0);
        finish_resp("t2", resp);
        check("t2_reg1_merge", dut_reg(1), 32'h112233AA);
        check_regs("t2");

        // 3: index 16 is out of range.
        model_write(8'h40, 32'h55555555, 4'hF, resp);
        send(8'h40, 32'h55555555, 4'hF, 0, 0);
        finish_resp("t3", resp);
        check("t3_bresp_slverr", resp, 2'b10);
        check("t3_cnt", slverr_cnt, exp_cnt);
        check_regs("t3");

        // 4: BREADY low for 7 cycles with an SLVERR response pending.
        bready = 1'b0;
        model_write(8'h80, 32'h12345678, 4'hF, resp);
        send(8'h80, 32'h12345678, 4'hF, 0, 0);
        wait_bvalid();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t4_hold%0d_bvalid", i), bvalid, 1'b1);
            check($sformatf("t4_hold%0d_bresp", i), bresp, 2'b10);
            check($sformatf("t4_hold%0d_awready", i), awready, 1'b0);
            check($sformatf("t4_hold%0d_wready", i), wready, 1'b0);
            tick();
        end
        bready = 1'b1;
        tick();
        check("t4_bvalid_drop", bvalid, 1'b0);
        check("t4_idle_awready", awready, 1'b1);
        check("t4_idle_wready", wready, 1'b1);
        check("t4_cnt", slverr_cnt, exp_cnt);

        // 5: reset while a response is pending.
        bready = 1'b0;
        send(8'h10, 32'hCAFEF00D, 4'hF, 0, 0);
        wait_bvalid();
        tick();
        #2 rst_n = 1'b0;
        model_clear();
        #1 check("t5_async_bvalid", bvalid, 1'b0);
        check("t5_async_awready", awready, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("t5_release_bvalid", bvalid, 1'b0);
        check("t5_cnt_cleared", slverr_cnt, 8'd0);
        check_regs("t5_rst");
        tick();
        check("t5_first_edge_bvalid", bvalid, 1'b0);
        bready = 1'b1;
        model_write(8'h14, 32'h0BADC0DE, 4'hF, resp);
        send(8'h14, 32'h0BADC0DE, 4'hF, 0, 0);
        finish_resp("t5_after", resp);
        check_regs("t5");

        // 6: 300 out-of-range writes saturate the counter.
        for (int i = 0; i < 300; i++) begin
            model_write(8'hFC, 32'hA5A5A5A5, 4'hF, resp);
            send(8'hFC, 32'hA5A5A5A5, 4'hF, 0, 0);
            finish_resp($sformatf("t6_%0d", i), resp);
            if (i == 254) check("t6_cnt_at_255", slverr_cnt, 8'd255);
        end
        check("t6_cnt_saturated", slverr_cnt, 8'd255);
        check("t6_cnt_model", slverr_cnt, exp_cnt);
        check_regs("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
